// File: rtl/output_stream_buffer_if.sv
// rtl/output_stream_buffer_if.sv - streamed result port of the output buffer
interface output_stream_buffer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic              out_written;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output out_data, out_written, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_written, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/output_stream_buffer.sv
// rtl/output_stream_buffer.sv - multi-lane result buffer with burst streaming and clear-on-read
module output_stream_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_base,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    rd_start,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [ADDR_W:0]         rd_len,
  input  logic                    rd_clear,
  output_stream_buffer_if.master  out_if,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W:0]         written_count
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              clear_q;
  logic [ADDR_W:0]   pop;

  logic              accept, hs, last_hs, load, load_clear;
  logic [ADDR_W-1:0] load_addr;

  assign accept     = (state_q == IDLE) && rd_start && (rd_len != '0);
  assign hs         = (state_q == STREAM) && out_if.out_ready;
  assign last_hs    = hs && (remaining_q == LEN_ONE);
  assign load       = accept || (hs && !last_hs);
  assign load_addr  = accept ? rd_addr : ptr_q + ADDR_W'(1);
  assign load_clear = accept ? rd_clear : clear_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = STREAM;
      STREAM:  if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q == STREAM);
    out_if.out_valid = (state_q == STREAM);
    out_if.out_last  = (state_q == STREAM) && (remaining_q == LEN_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q              <= '0;
      remaining_q        <= '0;
      clear_q            <= 1'b0;
      done               <= 1'b0;
      out_if.out_data    <= '0;
      out_if.out_written <= 1'b0;
    end else begin
      done <= last_hs;
      if (accept) begin
        ptr_q       <= rd_addr;
        remaining_q <= rd_len;
        clear_q     <= rd_clear;
      end else if (hs) begin
        ptr_q       <= ptr_q + ADDR_W'(1);
        remaining_q <= remaining_q - LEN_ONE;
      end
      if (load) begin
        out_if.out_data    <= mem[load_addr];
        out_if.out_written <= written[load_addr];
      end
    end
  end

  // Lane writes come after the read-clear so a colliding write keeps its written bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else begin
      if (load && load_clear) written[load_addr] <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (wr_en && wr_mask[i]) begin
          mem[wr_base + ADDR_W'(i)]     <= wr_data[i*DATA_W +: DATA_W];
          written[wr_base + ADDR_W'(i)] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < DEPTH; i++) pop = pop + {{ADDR_W{1'b0}}, written[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) written_count <= '0;
    else     written_count <= pop;
  end
endmodule

// File: tb/tb_output_stream_buffer.sv
// tb/tb_output_stream_buffer.sv - directed bench with a per-cycle reference model of the buffer
module tb_output_stream_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LANES  = 4;
  localparam int ADDR_W = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    wr_en = 1'b0;
  logic [ADDR_W-1:0]       wr_base = '0;
  logic [LANES-1:0]        wr_mask = '0;
  logic [LANES*DATA_W-1:0] wr_data = '0;
  logic                    rd_start = 1'b0;
  logic [ADDR_W-1:0]       rd_addr = '0;
  logic [ADDR_W:0]         rd_len = '0;
  logic                    rd_clear = 1'b0;
  logic                    busy, done;
  logic [ADDR_W:0]         written_count;

  output_stream_buffer_if #(.DATA_W(DATA_W)) bus ();

  output_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_base(wr_base), .wr_mask(wr_mask),
    .wr_data(wr_data), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_clear(rd_clear), .out_if(bus.master), .busy(busy), .done(done),
    .written_count(written_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: burst = (pointer, words left); memory and written flags as plain arrays.
  int unsigned m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  bit          m_busy, m_clr, m_valid, m_last, m_done, m_written;
  int          m_ptr, m_rem, m_count;
  int unsigned m_data;

  always @(posedge clk) begin
    bit was_busy, do_load;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_wr[i] = 0; end
      m_busy = 0; m_clr = 0; m_ptr = 0; m_rem = 0; m_count = 0;
      m_data = 0; m_written = 0; m_done = 0;
    end else begin
      m_count = 0;
      for (int i = 0; i < DEPTH; i++) m_count += m_wr[i];
      was_busy = m_busy;
      do_load = 0;
      m_done = 0;
      if (was_busy && bus.out_ready) begin
        if (m_rem == 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_ptr = (m_ptr + 1) % DEPTH;
          m_rem--;
          do_load = 1;
        end
      end
      if (!was_busy && rd_start && rd_len != 0) begin
        m_busy = 1; m_ptr = rd_addr; m_rem = rd_len; m_clr = rd_clear;
        do_load = 1;
      end
      if (do_load) begin
        m_data = m_mem[m_ptr];
        m_written = m_wr[m_ptr];
        if (m_clr) m_wr[m_ptr] = 0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (wr_en && wr_mask[i]) begin
          m_mem[(wr_base + i) % DEPTH] = wr_data[i*DATA_W +: DATA_W];
          m_wr[(wr_base + i) % DEPTH] = 1;
        end
      end
    end
    m_valid = m_busy;
    m_last  = m_busy && (m_rem == 1);
  end

  logic [DATA_W-1:0] cap_d [$];
  bit                cap_w [$];

  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("out_last", bus.out_last, m_last);
    chk("written_count", written_count, m_count);
    if (m_valid) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_written", bus.out_written, m_written);
    end
    if (bus.out_valid && bus.out_ready) begin
      cap_d.push_back(bus.out_data);
      cap_w.push_back(bus.out_written);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int addr, input int len, input bit clr);
    cap_d.delete();
    cap_w.delete();
    rd_addr = addr[ADDR_W-1:0];
    rd_len = len[ADDR_W:0];
    rd_clear = clr;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input bit bp);
    bit [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (!done && n < 200) begin
      if (bp) bus.out_ready = pat[n % 4];
      tick();
      n++;
    end
    bus.out_ready = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected done pulse at %0t", $time);
    end
  endtask

  task automatic chk_burst(input string name, input logic [DATA_W-1:0] d [], input bit w []);
    chk({name, "_len"}, cap_d.size(), d.size());
    for (int i = 0; i < d.size() && i < cap_d.size(); i++) begin
      chk({name, "_data"}, cap_d[i], d[i]);
      chk({name, "_wr"}, cap_w[i], w[i]);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_count", written_count, 0);
    chk("reset_busy", busy, 0);

    start_burst(3, 0, 0);
    chk("len0_busy", busy, 0);

    wr_en = 1'b1; wr_base = 4'd14; wr_mask = 4'b1111;
    wr_data = {32'd4, 32'd3, 32'd2, 32'd1};
    tick();
    wr_en = 1'b0;
    tick();
    chk("par_write_count", written_count, 4);

    start_burst(14, 4, 0);
    wait_done(0);
    chk_burst("burst", '{1, 2, 3, 4}, '{1, 1, 1, 1});

    start_burst(14, 4, 0);
    wait_done(1);
    chk_burst("backpressure", '{1, 2, 3, 4}, '{1, 1, 1, 1});

    start_burst(14, 4, 1);
    wait_done(0);
    chk_burst("clear_first", '{1, 2, 3, 4}, '{1, 1, 1, 1});
    tick();
    tick();
    chk("clear_count", written_count, 0);
    start_burst(14, 4, 0);
    wait_done(0);
    chk_burst("clear_second", '{1, 2, 3, 4}, '{0, 0, 0, 0});

    wr_en = 1'b1; wr_base = 4'd6; wr_mask = 4'b0001;
    wr_data = {96'd0, 32'hAA};
    start_burst(6, 1, 1);
    wr_en = 1'b0;
    wait_done(0);
    chk_burst("collide_old", '{0}, '{0});
    start_burst(6, 1, 0);
    wait_done(0);
    chk_burst("collide_new", '{32'hAA}, '{1});

    cap_d.delete();
    cap_w.delete();
    rd_addr = 4'd10; rd_len = 5'd16; rd_clear = 1'b0; rd_start = 1'b1;
    tick();
    wait_done(0);
    tick();
    rd_start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done(0);
    chk("wrap_words", cap_d.size(), 32);

    start_burst(2, 16, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("rst_count", written_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
